// File: rtl/j17_pkg.sv
// Shared definitions for the J17 control unit: opcode map, instruction field
// positions, FSM state encodings and the decoded control bundle.
package j17_pkg;

    localparam logic [4:0] OP_ALU_MAX = 5'd11;
    localparam logic [4:0] OP_MOV     = 5'd12;
    localparam logic [4:0] OP_STORE   = 5'd13;
    localparam logic [4:0] OP_BEQ     = 5'd14;
    localparam logic [4:0] OP_JMP     = 5'd20;
    localparam logic [4:0] OP_NOP     = 5'd21;
    localparam logic [4:0] OP_HALT    = 5'd31;

    localparam int OPC_HI    = 31;
    localparam int OPC_LO    = 27;
    localparam int OP1_HI    = 26;
    localparam int OP1_LO    = 24;
    localparam int IMM_BIT   = 23;
    localparam int FLAG_BIT  = 22;
    localparam int FLAG1_BIT = 21;
    localparam int OP2_HI    = 20;
    localparam int OP2_LO    = 0;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_MEM    = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [1:0] RAM_IDLE  = 2'b00;
    localparam logic [1:0] RAM_WRITE = 2'b01;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_NUM2 = 2'd1;

    typedef struct packed {
        logic [4:0]  alucode;
        logic [2:0]  op1;
        logic [20:0] op2;
        logic        im_control;
        logic        flag;
        logic        flag1;
        logic        regenable;
        logic [1:0]  ramenable;
        logic [2:0]  pc_control;
        logic [1:0]  writecode;
        logic        illegal;
        logic        halt;
    } ctrl_t;

endpackage

// File: rtl/j17_control_if.sv
// Instruction fetch handshake between the control unit and instruction memory.
interface j17_control_if;
    logic        instr_req;
    logic        instr_valid;
    logic [31:0] instr_data;

    modport master (output instr_req, input instr_valid, input instr_data);
    modport slave  (input instr_req, output instr_valid, output instr_data);
endinterface

// File: rtl/j17_decode.sv
// Purely combinational J17 instruction decoder: IR to control bundle plus
// illegal/halt classification.
module j17_decode
    import j17_pkg::*;
(
    input  logic [31:0] ir,
    output ctrl_t       ctrl
);

    logic [4:0] opc_s;

    assign opc_s = ir[OPC_HI:OPC_LO];

    // Field extraction and opcode classification
    always_comb begin
        ctrl            = '0;
        ctrl.op1        = ir[OP1_HI:OP1_LO];
        ctrl.op2        = ir[OP2_HI:OP2_LO];
        ctrl.im_control = ir[IMM_BIT];
        ctrl.flag       = ir[FLAG_BIT];
        ctrl.flag1      = ir[FLAG1_BIT];
        if (opc_s <= OP_ALU_MAX) begin
            ctrl.alucode   = opc_s;
            ctrl.writecode = WB_ALU;
            ctrl.regenable = 1'b1;
        end else begin
            case (opc_s)
                OP_MOV: begin
                    ctrl.writecode = WB_NUM2;
                    ctrl.regenable = 1'b1;
                end
                OP_STORE: ctrl.ramenable = RAM_WRITE;
                OP_NOP:   ctrl.halt = 1'b0;
                OP_HALT:  ctrl.halt = 1'b1;
                default: begin
                    // Branches map BEQ..JMP onto condition selects 1..7
                    if ((opc_s >= OP_BEQ) && (opc_s <= OP_JMP)) begin
                        ctrl.pc_control = 3'(opc_s - OP_STORE);
                    end else begin
                        ctrl.illegal = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/j17_control.sv
// J17 multi-cycle control unit: fetch/decode/mem-wait/execute sequencing with
// registered control outputs and a one-cycle PC advance strobe per instruction.
module j17_control
    import j17_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int COUNT_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    j17_control_if.master      bus,
    output logic [4:0]         alucode,
    output logic [2:0]         op1,
    output logic [20:0]        op2,
    output logic               imControl,
    output logic               flag,
    output logic               flag1,
    output logic               regenable,
    output logic [1:0]         ramenable,
    output logic [2:0]         pcControl,
    output logic [1:0]         writecode,
    output logic               pc_en,
    output logic               halted,
    output logic               illegal,
    output logic [COUNT_W-1:0] retired
);

    localparam int WCNT_W    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam int WAIT_LOAD = (MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [31:0]       ir_r;
    logic [WCNT_W-1:0] wait_r;
    logic              instr_req_r;
    logic              accept_s;
    logic              mem_op_s;
    logic              to_exec_s;
    ctrl_t             dec_s;

    j17_decode u_decode (
        .ir   (ir_r),
        .ctrl (dec_s)
    );

    assign bus.instr_req = instr_req_r;
    // A word offered before the request is raised is simply not taken
    assign accept_s  = (state_r == ST_FETCH) && instr_req_r && bus.instr_valid;
    assign mem_op_s  = (dec_s.flag | dec_s.flag1) && (MEM_WAIT > 0);
    assign to_exec_s = (state_nxt_s == ST_EXEC);

    // Next-state selection
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (accept_s) state_nxt_s = ST_DECODE;
                else          state_nxt_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (dec_s.halt)    state_nxt_s = ST_HALT;
                else if (mem_op_s) state_nxt_s = ST_MEM;
                else               state_nxt_s = ST_EXEC;
            end
            ST_MEM: begin
                if (wait_r == '0) state_nxt_s = ST_EXEC;
                else              state_nxt_s = ST_MEM;
            end
            ST_EXEC: state_nxt_s = ST_FETCH;
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_FETCH;
        endcase
    end

    // State, instruction register, fetch request and RAM wait counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_FETCH;
            ir_r        <= 32'd0;
            instr_req_r <= 1'b0;
            wait_r      <= '0;
        end else begin
            state_r     <= state_nxt_s;
            instr_req_r <= (state_nxt_s == ST_FETCH);
            if (accept_s) begin
                ir_r <= bus.instr_data;
            end
            if ((state_r == ST_DECODE) && mem_op_s) begin
                wait_r <= WCNT_W'(WAIT_LOAD);
            end else if ((state_r == ST_MEM) && (wait_r != '0)) begin
                wait_r <= wait_r - WCNT_W'(1);
            end
        end
    end

    // Decoded fields captured in DECODE and held until the next DECODE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alucode   <= 5'd0;
            op1       <= 3'd0;
            op2       <= 21'd0;
            imControl <= 1'b0;
            flag      <= 1'b0;
            flag1     <= 1'b0;
            writecode <= 2'd0;
            illegal   <= 1'b0;
        end else if (state_r == ST_DECODE) begin
            alucode   <= dec_s.alucode;
            op1       <= dec_s.op1;
            op2       <= dec_s.op2;
            imControl <= dec_s.im_control;
            flag      <= dec_s.flag;
            flag1     <= dec_s.flag1;
            writecode <= dec_s.writecode;
            illegal   <= illegal | dec_s.illegal;
        end
    end

    // Execute strobes: registered on entry to EXEC so they last exactly one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_en     <= 1'b0;
            regenable <= 1'b0;
            ramenable <= RAM_IDLE;
            pcControl <= 3'd0;
            halted    <= 1'b0;
            retired   <= '0;
        end else begin
            pc_en     <= to_exec_s;
            regenable <= to_exec_s && dec_s.regenable;
            ramenable <= to_exec_s ? dec_s.ramenable : RAM_IDLE;
            pcControl <= to_exec_s ? dec_s.pc_control : 3'd0;
            halted    <= (state_nxt_s == ST_HALT);
            if (to_exec_s) begin
                retired <= retired + COUNT_W'(1);
            end
        end
    end

endmodule

// File: doc/j17_control.md
Name: j17_control

Overview:
- Multi-cycle control unit for the J17 core.
- Fetches a 32-bit instruction word at the current PC and decodes it into the control bundle the datapath consumes: alucode, op1, op2, imControl, flag, flag1, regenable, ramenable, pcControl, writecode.
- Sequences each instruction through fetch, decode, optional RAM-wait and execute.
- Emits a one-cycle pc_en strobe so the PC advances exactly once per retired instruction.

Parameters:
- MEM_WAIT, 1, extra cycles held in MEM when an operand comes from RAM (0 = skip MEM).
- COUNT_W, 16, width of retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_req  out  1  fetch request; high only in FETCH.
- instr_valid  in  1  instruction word valid; accepted only when instr_req=1.
- instr_data  in  32  instruction word.
- alucode  out  5  ALU operation.
- op1  out  3  destination/first register index.
- op2  out  21  second operand: register fields or immediate.
- imControl  out  1  op2 is immediate.
- flag  out  1  operand 1 from RAM.
- flag1  out  1  operand 2 from RAM.
- regenable  out  1  register write strobe.
- ramenable  out  2  RAM control; 2'b01 = write.
- pcControl  out  3  branch condition select.
- writecode  out  2  writeback source: 0 = ALU result, 1 = num2.
- pc_en  out  1  PC update strobe.
- halted  out  1  HALT executed.
- illegal  out  1  sticky: illegal opcode seen.
- retired  out  COUNT_W  retired instruction count.

Behaviour:
- Instruction format:
  - [31:27] opcode
  - [26:24] op1
  - [23] imm
  - [22] flag
  - [21] flag1
  - [20:0] op2
- Opcode map:
  - 0-11: ALU ops; alucode=opcode, writecode=0, regenable=1.
  - 12: MOV; alucode=0, writecode=1, regenable=1.
  - 13: STORE; ramenable=2'b01, regenable=0.
  - 14-20: branches; pcControl=opcode-13 (14→1 BEQ … 20→7 JMP), regenable=0.
  - 21: NOP.
  - 22-30: illegal.
  - 31: HALT.
- States: FETCH, DECODE, MEM, EXEC, HALT.
- FETCH:
  - instr_req=1.
  - On instr_valid, latch instr_data into IR and go to DECODE.
  - instr_valid while instr_req=0 is ignored.
- DECODE (one cycle):
  - Register all field/decoded outputs from IR.
  - HALT opcode → HALT state.
  - Else if (flag|flag1) and MEM_WAIT>0 → MEM, loading wait counter to MEM_WAIT-1.
  - Else → EXEC.
- MEM: count down; at 0 → EXEC.
- EXEC (exactly one cycle):
  - pc_en=1.
  - regenable and ramenable asserted per decode.
  - retired increments.
  - Next state FETCH.
- HALT:
  - halted=1, instr_req=0, pc_en=0, all strobes 0.
  - Held until reset.
- Strobe gating:
  - regenable, ramenable and pc_en are 0 in every state except EXEC.
  - pcControl is 0 outside EXEC.
- Field hold: op1, op2, alucode, imControl, flag, flag1 and writecode hold their value from DECODE until the next DECODE.
- Latency: with fetch accepted at cycle N, EXEC is N+2 without a memory operand, or N+2+MEM_WAIT when flag|flag1.
- Illegal opcode:
  - illegal set (sticky).
  - Executes as NOP: pc_en=1, no register or RAM write, retired increments.
- retired wraps modulo 2^COUNT_W.
- Reset (asynchronous, any state including MEM/EXEC):
  - State → FETCH.
  - All outputs 0, IR 0.
  - retired=0, illegal=0, halted=0.
  - instr_req rises on the first clock after reset deasserts.

Decomposition:
- Package j17_pkg holds:
  - opcode localparams (OP_MOV=12, OP_STORE=13, OP_BEQ=14, OP_JMP=20, OP_NOP=21, OP_HALT=31);
  - field bit positions;
  - state enum;
  - ramenable encodings.
- Sub-module j17_decode: purely combinational, IR → control bundle plus illegal/halt flags.
- j17_control wraps j17_decode with the FSM and registers.

Test Plan:
- ADD immediate: instr 0x0B800005 (op=1, op1=3, imm, op2=5), accepted cycle N → at N+2: alucode=1, op1=3, op2=5, imControl=1, regenable=1, pc_en=1; retired=1.
- BEQ: instr 0x71000000 → EXEC has pcControl=1, regenable=0, ramenable=0, pc_en=1 for exactly one cycle.
- RAM operand, MEM_WAIT=2: MOV with flag, instr 0x60400000 → flag=1, EXEC at N+4, writecode=1; pc_en low through both MEM cycles.
- Illegal: instr 0xB0000000 → illegal=1 and stays 1; pc_en=1, regenable=0, retired increments; next FETCH proceeds normally.
- HALT: instr 0xF8000000 → halted=1 at N+2; instr_req stays 0 and pc_en stays 0 for 20 cycles while instr_valid is held high.
- Reset during MEM: assert reset mid-wait → all outputs 0 immediately, without waiting for a clock edge; after release, instr_req=1 next cycle and retired=0.
